// File: rtl/bus_timer_responder_pkg.sv
// Shared definitions for the bus timer responder: register map, CTRL/STATUS bit
// positions, FSM state types and the PERIOD reset value.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_RELOAD    = 1;
  localparam int unsigned CTRL_IRQ_EN    = 2;
  localparam int unsigned STATUS_EXPIRED = 0;

  localparam logic [7:0] PERIOD_RESET = 8'hFF;

  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} timer_state_t;
  typedef enum logic {IRQ_IDLE, IRQ_RAISED} irq_state_t;

endpackage

// File: rtl/bus_timer_responder_if.sv
// Processor bus as seen by the timer: address, write strobe, shared data lines
// and the interrupt raise/ack pair.
interface bus_timer_responder_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;
  logic [7:0] host_data;
  logic [7:0] resp_data;
  logic       resp_oe;
  wire  [7:0] BUS_DATA;

  // Both bus sides resolve onto the shared lines here; undriven lines float.
  assign BUS_DATA = resp_oe ? resp_data : (BUS_WE ? host_data : 'z);

  modport slave (
    input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, BUS_DATA,
    output BUS_INTERRUPT_RAISE, resp_data, resp_oe
  );

  modport master (
    output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, host_data,
    input  BUS_DATA, BUS_INTERRUPT_RAISE, resp_data, resp_oe
  );
endinterface

// File: rtl/bus_timer_responder_tick_prescaler.sv
// Divides CLK down to a one-cycle tick every PRESCALE cycles while run is high;
// clr restarts the division from zero.
module tick_prescaler #(
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PRESCALE_W'(1);
    end
  end
endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped timer on the shared 8-bit processor bus: four-register window,
// tick-driven expiry counter, sticky status and a level interrupt held until acked.
module bus_timer_responder
  import timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = 8'hF0,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_timer_responder_if.slave  bus
);
  logic [2:0]   ctrl;
  logic [7:0]   period;
  logic [7:0]   count;
  logic         status;
  timer_state_t tstate;
  irq_state_t   istate;
  logic [7:0]   rd_data;
  logic         rd_oe;
  logic [7:0]   rd_mux;

  logic       hit, wr, rd;
  logic [1:0] offset;
  logic [7:0] wdata;
  logic       ctrl_wr, period_wr, status_wr, timer_wr;
  logic       tick_raw, tick, expire;

  assign hit       = (bus.BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign wr        = hit && bus.BUS_WE;
  assign rd        = hit && !bus.BUS_WE;
  assign offset    = bus.BUS_ADDR[1:0];
  assign wdata     = bus.BUS_DATA;
  assign ctrl_wr   = wr && (offset == REG_CTRL);
  assign period_wr = wr && (offset == REG_PERIOD);
  assign status_wr = wr && (offset == REG_STATUS);

  // Only writes that reshape the timer discard a coincident tick; a STATUS
  // write must still see the expiry so that set can win over clear.
  assign timer_wr = ctrl_wr || period_wr;
  assign tick     = tick_raw && !timer_wr;
  assign expire   = tick && (count == period);

  tick_prescaler #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (ctrl_wr),
    .run   (tstate == RUNNING),
    .tick  (tick_raw)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl   <= '0;
      period <= PERIOD_RESET;
      count  <= '0;
      tstate <= STOPPED;
    end else if (ctrl_wr) begin
      ctrl   <= wdata[2:0];
      count  <= '0;
      tstate <= wdata[CTRL_EN] ? RUNNING : STOPPED;
    end else begin
      if (period_wr)
        period <= wdata;
      case (tstate)
        RUNNING: begin
          if (tick) begin
            if (expire) begin
              if (ctrl[CTRL_RELOAD])
                count <= '0;
              else
                tstate <= EXPIRED;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      status <= 1'b0;
    else if (expire)
      status <= 1'b1;
    else if (status_wr && wdata[STATUS_EXPIRED])
      status <= 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      istate <= IRQ_IDLE;
    else if (ctrl_wr && !wdata[CTRL_IRQ_EN])
      istate <= IRQ_IDLE;
    else if (expire && ctrl[CTRL_IRQ_EN])
      istate <= IRQ_RAISED;
    else if (bus.BUS_INTERRUPT_ACK)
      istate <= IRQ_IDLE;
  end

  assign bus.BUS_INTERRUPT_RAISE = (istate == IRQ_RAISED);

  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_CTRL:   rd_mux = {5'b0, ctrl};
      REG_PERIOD: rd_mux = period;
      REG_COUNT:  rd_mux = count;
      REG_STATUS: rd_mux = {7'b0, status};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_data <= '0;
      rd_oe   <= 1'b0;
    end else begin
      rd_oe <= rd;
      if (rd)
        rd_data <= rd_mux;
    end
  end

  assign bus.resp_data = rd_data;
  assign bus.resp_oe   = rd_oe;
endmodule

// File: tb/tb_bus_timer_responder.sv
// Scenario bench for bus_timer_responder (PRESCALE=4, BASE_ADDR=F0): read data is
// scoreboarded, interrupt and drive-enable timing is checked inline per scenario.
module tb_bus_timer_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_timer_responder_if bus_if();

  bus_timer_responder #(
    .BASE_ADDR  (8'hF0),
    .PRESCALE   (4),
    .PRESCALE_W (16)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] expv;

  initial begin
    bus_if.BUS_ADDR          = 8'h00;
    bus_if.BUS_WE            = 1'b0;
    bus_if.BUS_INTERRUPT_ACK = 1'b0;
    bus_if.host_data         = 8'h00;
  end

  // Every driven response cycle must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus_if.resp_oe === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: data %h driven with no read pending", bus_if.BUS_DATA);
      end else begin
        expv = sb.pop_front();
        if (bus_if.BUS_DATA !== expv) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", bus_if.BUS_DATA, expv);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic op_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.BUS_ADDR = a; bus_if.BUS_WE = 1'b1; bus_if.host_data = d; bus_if.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic op_read(input logic [7:0] a, input logic [7:0] e);
    @(negedge clk);
    bus_if.BUS_ADDR = a; bus_if.BUS_WE = 1'b0; bus_if.BUS_INTERRUPT_ACK = 1'b0;
    sb.push_back(e);
  endtask

  task automatic op_read_miss(input logic [7:0] a);
    @(negedge clk);
    bus_if.BUS_ADDR = a; bus_if.BUS_WE = 1'b0; bus_if.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic op_idle();
    @(negedge clk);
    bus_if.BUS_ADDR = 8'h00; bus_if.BUS_WE = 1'b0; bus_if.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic op_ack();
    @(negedge clk);
    bus_if.BUS_ADDR = 8'h00; bus_if.BUS_WE = 1'b0; bus_if.BUS_INTERRUPT_ACK = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_raise: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
    checks++;
    if (bus_if.resp_oe !== 1'b0) begin
      errors++; $display("FAIL reset_oe: got %b expected 0", bus_if.resp_oe);
    end
    rst_n = 1'b1;
    op_write(8'hF1, 8'h02);
    op_write(8'hF0, 8'h07);
    for (int i = 0; i < 20 && bus_if.BUS_INTERRUPT_RAISE !== 1'b1; i++) op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL reset_setup_raise: got %b expected 1", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_idle();
    op_idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_async_raise: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
    checks++;
    if (bus_if.resp_oe !== 1'b0) begin
      errors++; $display("FAIL reset_async_oe: got %b expected 0", bus_if.resp_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op_read(8'hF0, 8'h00);
    op_read(8'hF1, 8'hFF);
    op_read(8'hF2, 8'h00);
    op_read(8'hF3, 8'h00);
    op_idle();
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_after_raise: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
  endtask

  task automatic test_oneshot();
    op_write(8'hF1, 8'h03);
    op_write(8'hF0, 8'h05);
    repeat (16) op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL oneshot_early: got %b expected 0 at cycle 15", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL oneshot_raise: got %b expected 1 at cycle 16", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_read(8'hF2, 8'h03);
    op_read(8'hF3, 8'h01);
    op_read(8'hF0, 8'h05);
    op_idle();
    repeat (8) op_idle();
    op_read(8'hF2, 8'h03);
    op_idle();
  endtask

  task automatic test_handshake();
    op_ack();
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL ack_clear: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_ack();
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL ack_when_idle: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
  endtask

  task automatic test_autoreload();
    op_write(8'hF0, 8'h00);
    op_write(8'hF3, 8'h01);
    op_idle();
    op_read(8'hF3, 8'h00);
    op_idle();
    op_write(8'hF1, 8'h01);
    op_write(8'hF0, 8'h07);
    repeat (8) op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reload_early: got %b expected 0 at cycle 7", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL reload_first: got %b expected 1 at cycle 8", bus_if.BUS_INTERRUPT_RAISE);
    end
    repeat (6) op_idle();
    op_ack();
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL ack_on_expiry: got %b expected 1", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_ack();
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reload_ack: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
    repeat (5) op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reload_third_early: got %b expected 0 at cycle 23", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL reload_third: got %b expected 1 at cycle 24", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_write(8'hF0, 8'h03);
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL irq_en_clear: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_read(8'hF3, 8'h01);
    op_idle();
    op_write(8'hF0, 8'h00);
  endtask

  task automatic test_decode();
    op_read_miss(8'hF4);
    op_read_miss(8'h00);
    checks++;
    if (bus_if.resp_oe !== 1'b0) begin
      errors++; $display("FAIL decode_f4: drive enable %b expected 0", bus_if.resp_oe);
    end
    op_idle();
    checks++;
    if (bus_if.resp_oe !== 1'b0) begin
      errors++; $display("FAIL decode_00: drive enable %b expected 0", bus_if.resp_oe);
    end
    op_write(8'hF2, 8'h55);
    op_idle();
    op_read(8'hF2, 8'h00);
    op_read(8'hF1, 8'h01);
    op_idle();
    op_write(8'hF0, 8'hFA);
    op_idle();
    op_read(8'hF0, 8'h02);
    op_idle();
    op_write(8'hF0, 8'h00);
  endtask

  task automatic test_contention();
    op_write(8'hF3, 8'h01);
    op_write(8'hF1, 8'h00);
    op_write(8'hF0, 8'h01);
    repeat (3) op_idle();
    op_write(8'hF3, 8'h01);
    op_idle();
    op_read(8'hF3, 8'h01);
    op_idle();
    checks++;
    if (bus_if.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL contention_no_irq: got %b expected 0", bus_if.BUS_INTERRUPT_RAISE);
    end
    op_write(8'hF1, 8'h05);
    op_write(8'hF0, 8'h01);
    repeat (3) op_idle();
    op_write(8'hF1, 8'h05);
    op_read(8'hF2, 8'h00);
    repeat (3) op_idle();
    op_read(8'hF2, 8'h01);
    repeat (2) op_idle();
    op_write(8'hF0, 8'h01);
    op_read(8'hF2, 8'h00);
    op_idle();
    op_write(8'hF0, 8'h00);
    op_idle();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_handshake();
    test_autoreload();
    test_decode();
    test_contention();
    repeat (2) op_idle();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL reads_outstanding: %0d responses missing expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
